jh_src_packer: RTL and testbench

Input-side stage for the JH core. Accepts 32-bit bus writes, assembles them into 64-bit message words, and buffers them in a small FIFO. The FIFO feeds `jh_top` through its `src_ready`/`src_read` handshake, so the host can post several words ahead of the core instead of stalling on each one. It sits between the bus-facing register logic of the hash component and the `din`/`src_ready`/`src_read` pins of `jh_top`.

---
 rtl/jh_src_packer.sv | 73 +++++++
 tb/tb_jh_src_packer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jh_src_packer.sv
// Input-side stage for the JH core: assembles 32-bit bus writes into 64-bit
// message words and queues them in a small FIFO behind the src_ready/src_read handshake.
module jh_src_packer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic          swap,
    input  logic [31:0]   wdata,
    output logic          src_ready,
    input  logic          src_read,
    output logic [63:0]   dout,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [31:0]   lo;
    logic [31:0]   wval;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          pop;
    logic          accept;

    assign wval   = swap ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : wdata;
    assign pop    = src_read && (count != '0);
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign accept = wr_hi && ((count < DEPTH_C) || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            lo       <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            lo       <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_hi) begin
                if (accept) begin
                    mem[wp] <= {wval, lo};
                    wp      <= wp + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (wr_lo) begin
                lo <= wval;
            end
            if (pop) rp <= rp + 1'b1;
            if (accept && !pop)      count <= count + CW'(1);
            else if (pop && !accept) count <= count - CW'(1);
        end
    end

    assign src_ready = (count == '0);
    assign full      = (count == DEPTH_C);
    assign dout      = mem[rp];

endmodule

// File: tb/tb_jh_src_packer.sv
// Scoreboard bench for jh_src_packer: expected words are queued at push time and
// checked by a monitor whenever the consumer pops a valid head word.
module tb_jh_src_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_lo = 1'b0;
    logic        wr_hi = 1'b0;
    logic        swap = 1'b0;
    logic [31:0] wdata = '0;
    logic        src_ready;
    logic        src_read = 1'b0;
    logic [63:0] dout;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [63:0] sb [$];

    jh_src_packer #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_lo(wr_lo), .wr_hi(wr_hi),
        .swap(swap), .wdata(wdata), .src_ready(src_ready), .src_read(src_read),
        .dout(dout), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle word write; the expected word is queued only when the push should be accepted.
    task automatic push_word(input logic [31:0] lo_v, input logic [31:0] hi_v, input logic swp,
                             input logic [63:0] exp, input logic expect_accept, input logic pop_too);
        wr_lo = 1'b1; wdata = lo_v; swap = swp;
        cyc();
        wr_lo = 1'b0; wr_hi = 1'b1; wdata = hi_v; src_read = pop_too;
        if (expect_accept) sb.push_back(exp);
        cyc();
        wr_hi = 1'b0; swap = 1'b0; src_read = 1'b0;
    endtask

    task automatic pop_n(input int n);
        src_read = 1'b1;
        repeat (n) cyc();
        src_read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (src_read && !src_ready) begin
            if (sb.size() == 0) chk("unexpected_pop", dout, 64'hx);
            else chk("pop_data", dout, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) cyc();
        chk("rst_src_ready", 64'(src_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_dout", dout, 64'd0);
        reset_n = 1'b1;
        repeat (5) cyc();
        chk("idle_src_ready", 64'(src_ready), 64'd1);
        chk("idle_count", 64'(count), 64'd0);

        push_word(32'h11223344, 32'h55667788, 1'b0, 64'h5566778811223344, 1'b1, 1'b0);
        chk("basic_dout", dout, 64'h5566778811223344);
        chk("basic_src_ready", 64'(src_ready), 64'd0);
        chk("basic_count", 64'(count), 64'd1);
        pop_n(1);
        chk("basic_drained", 64'(src_ready), 64'd1);

        push_word(32'h01020304, 32'h0A0B0C0D, 1'b1, 64'h0D0C0B0A04030201, 1'b1, 1'b0);
        chk("swap_dout", dout, 64'h0D0C0B0A04030201);
        pop_n(1);

        for (int k = 1; k <= 4; k++) push_word(32'(k), 32'h0, 1'b0, 64'(k), 1'b1, 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_no_ovf", 64'(overflow), 64'd0);
        push_word(32'd5, 32'h0, 1'b0, 64'd5, 1'b0, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd4);
        pop_n(4);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_drained", 64'(count), 64'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_ovf_clr", 64'(overflow), 64'd0);

        for (int k = 1; k <= 4; k++) push_word(32'(k), 32'h0, 1'b0, 64'(k), 1'b1, 1'b0);
        push_word(32'd5, 32'h0, 1'b0, 64'd5, 1'b1, 1'b1);
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_no_ovf", 64'(overflow), 64'd0);
        pop_n(4);
        chk("pp_drained", 64'(count), 64'd0);

        for (int i = 0; i < 10; i++) begin
            push_word(~32'(i), 32'hA5A50000 | 32'(i), 1'b0,
                      {32'hA5A50000 | 32'(i), ~32'(i)}, 1'b1, 1'b0);
            pop_n(1);
        end
        chk("wrap_count", 64'(count), 64'd0);

        pop_n(1);
        chk("empty_read_count", 64'(count), 64'd0);
        chk("empty_read_ready", 64'(src_ready), 64'd1);

        wr_lo = 1'b1; wdata = 32'h77;
        cyc();
        wr_lo = 1'b0; wr_hi = 1'b1; flush = 1'b1; wdata = 32'h88;
        cyc();
        wr_hi = 1'b0; flush = 1'b0;
        chk("flush_wr_count", 64'(count), 64'd0);
        chk("flush_wr_ready", 64'(src_ready), 64'd1);

        push_word(32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 64'hCAFEF00DDEADBEEF, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(src_ready), 64'd1);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_dout", dout, 64'd0);
        sb.delete();
        cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("post_rst_count", 64'(count), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
